// File: rtl/soc_tracker_if.sv
// Bus bundle for soc_tracker: current-sample handshake, SOC init and per-cell status.
interface soc_tracker_if;
  logic [31:0] i_cell0, i_cell1, i_cell2, i_cell3;
  logic        sample_valid;
  logic        sample_ready;
  logic        init_valid;
  logic [31:0] init_soc;
  logic [31:0] soc0, soc1, soc2, soc3;
  logic        soc_valid;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [3:0]  sat_flag;

  modport master (
    output i_cell0, i_cell1, i_cell2, i_cell3, sample_valid, init_valid, init_soc,
    input  sample_ready, soc0, soc1, soc2, soc3, soc_valid, full, empty, sat_flag
  );

  modport slave (
    input  i_cell0, i_cell1, i_cell2, i_cell3, sample_valid, init_valid, init_soc,
    output sample_ready, soc0, soc1, soc2, soc3, soc_valid, full, empty, sat_flag
  );
endinterface

// File: rtl/soc_tracker.sv
// Four-cell coulomb-counting SOC tracker, one cell updated per cycle with clamping.
// Optional sticky clamp flags are enabled by defining SOC_TRACKER_SAT_FLAG_EN.
module soc_tracker #(
  parameter logic [31:0] SOC_MAX  = 32'h0064_0000,
  parameter int          DT_SHIFT = 10
) (
  input  logic          clk,
  input  logic          rst,
  soc_tracker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [31:0]        soc_q [4];
  logic [31:0]        soc_d [4];
  logic signed [31:0] cur_q [4];
  logic signed [31:0] cur_d [4];
  logic               cur_load;

  logic [31:0]        init_clamped;
  logic signed [31:0] delta;
  logic signed [33:0] upd_sum;
  logic signed [33:0] soc_max_s;
  logic [31:0]        upd_soc;

  assign init_clamped = (bus.init_soc > SOC_MAX) ? SOC_MAX : bus.init_soc;
  assign soc_max_s    = $signed({2'b00, SOC_MAX});

  // 34-bit signed sum: a full-scale SOC plus a full-scale negative delta cannot wrap.
  always_comb begin
    delta   = cur_q[idx_q] >>> DT_SHIFT;
    upd_sum = $signed({2'b00, soc_q[idx_q]}) + $signed({{2{delta[31]}}, delta});
    if (upd_sum < 0)              upd_soc = '0;
    else if (upd_sum > soc_max_s) upd_soc = SOC_MAX;
    else                          upd_soc = upd_sum[31:0];
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    soc_d    = soc_q;
    cur_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.init_valid) begin
          for (int k = 0; k < 4; k++) soc_d[k] = init_clamped;
        end else if (bus.sample_valid) begin
          state_d  = ACCUM;
          idx_d    = 2'd0;
          cur_load = 1'b1;
        end
      end
      ACCUM: begin
        soc_d[idx_q] = upd_soc;
        idx_d        = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_d = cur_q;
    if (cur_load) begin
      cur_d[0] = bus.i_cell0;
      cur_d[1] = bus.i_cell1;
      cur_d[2] = bus.i_cell2;
      cur_d[3] = bus.i_cell3;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      for (int k = 0; k < 4; k++) soc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      soc_q   <= soc_d;
    end
  end

  // NOTE: the latched currents are always reloaded before use, so they need no reset.
  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

`ifdef SOC_TRACKER_SAT_FLAG_EN
  logic [3:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (state_q == IDLE && bus.init_valid) begin
      sat_d = '0;
    end else if (state_q == ACCUM && (upd_sum < 0 || upd_sum > soc_max_s)) begin
      sat_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= '0;
    else     sat_q <= sat_d;
  end

  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 4'h0;
`endif

  assign bus.sample_ready = (state_q == IDLE) && !bus.init_valid;
  assign bus.soc_valid    = (state_q == DONE);
  assign bus.soc0         = soc_q[0];
  assign bus.soc1         = soc_q[1];
  assign bus.soc2         = soc_q[2];
  assign bus.soc3         = soc_q[3];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.full[k]  = (soc_q[k] == SOC_MAX);
      bus.empty[k] = (soc_q[k] == '0);
    end
  end

endmodule

// File: doc/soc_tracker.md
SOC_TRACKER -- requirements
Module: soc_tracker

Interface
REQ-001 Parameter SOC_MAX, default 32'h0064_0000, is the full-charge SOC (100.0 in unsigned Q16.16).
REQ-002 Parameter DT_SHIFT, default 10, is the arithmetic right shift converting one current sample to an SOC delta.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_cell0..i_cell3  input  32 each  per-cell current, signed Q16.16; positive means charge, negative means discharge.
REQ-006 sample_valid  input  1  current sample offered.
REQ-007 sample_ready  output  1  sample accepted this cycle if sample_valid=1.
REQ-008 init_valid  input  1  request to load init_soc into all four cells.
REQ-009 init_soc  input  32  initial SOC, unsigned Q16.16.
REQ-010 soc0..soc3  output  32 each  per-cell SOC, unsigned Q16.16, range 0..SOC_MAX.
REQ-011 soc_valid  output  1  one-cycle pulse when all four SOCs reflect the latest sample.
REQ-012 full  output  4  bit k=1 when socK==SOC_MAX.
REQ-013 empty  output  4  bit k=1 when socK==0.
REQ-014 sat_flag  output  4  sticky clamp-event flags (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-016 sample_ready SHALL equal (state==IDLE) && !init_valid.
REQ-017 In IDLE, init_valid=1 SHALL load min(init_soc, SOC_MAX) into all four SOC registers on that edge, with no soc_valid pulse.
REQ-018 In IDLE, init_valid=1 and sample_valid=1 in the same cycle: init wins and the sample is not accepted.
REQ-019 init_valid SHALL be ignored outside IDLE.
REQ-020 On sample acceptance, the four currents SHALL be latched; later input changes do not affect the update in progress.
REQ-021 On sample acceptance, the FSM SHALL go IDLE->ACCUM with the cell index at 0.
REQ-022 In ACCUM, one cell per cycle (index 0..3) SHALL be updated as socK <= clamp(socK + (i_cellK >>> DT_SHIFT), 0, SOC_MAX).
REQ-023 The update sum SHALL be computed signed at 34 bits so no wrap-around occurs before clamping.
REQ-024 After index 3 the FSM SHALL go ACCUM->DONE; DONE SHALL assert soc_valid for one cycle and return to IDLE.
REQ-025 Latency SHALL be: acceptance at edge N, soc0..soc3 updated at edges N+1..N+4, soc_valid high during the cycle after edge N+4, sample_ready high again after edge N+5.
REQ-026 full and empty SHALL be combinational decodes of the SOC registers.
REQ-027 A zero current SHALL leave the SOC unchanged and still produce soc_valid.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, index 0, soc0..soc3=0, soc_valid=0, sat_flag=0; hence empty=4'hF, full=0, sample_ready=1 once rst and init_valid are low.
REQ-029 Reset asserted during ACCUM SHALL abandon the update with no soc_valid pulse.

Configuration
REQ-030 With SOC_TRACKER_SAT_FLAG_EN defined, sat_flag[k] SHALL set when a cell-k update clamps (at 0 or SOC_MAX), stay set until reset or an accepted init, and init SHALL clear all flags.
REQ-031 With SOC_TRACKER_SAT_FLAG_EN undefined, sat_flag SHALL be tied to 4'h0 and no flag registers SHALL exist.

Verification
REQ-032 Reset, then init_valid with init_soc=32'h0032_0000 -> all soc=32'h0032_0000, full=0, empty=0, no soc_valid.
REQ-033 From 50.0, sample with i_cell0=32'h0001_0000 and other cells 0 -> soc0=32'h0032_0040 at edge N+1, soc_valid pulse after edge N+4, soc1..3 unchanged.
REQ-034 From 32'h0063_FFF0, i_cell2=32'h0010_0000 -> soc2=SOC_MAX, full[2]=1, sat_flag[2]=1 if macro defined, else 0.
REQ-035 From 0, i_cell3=32'hFFFF_0000 -> soc3=0, empty[3]=1, no wrap to a large value.
REQ-036 init_valid and sample_valid high together in IDLE -> init applied, sample_ready=0, no ACCUM entry; second sample during ACCUM -> not accepted.
REQ-037 rst pulse at edge N+2 of an update -> all soc=0, no soc_valid, sample_ready=1 after release.
